// File: rtl/vector_update_sequencer.sv
// vector_update_sequencer: drives one element-wise CG vector update pass.
// Issues per-word read strobes (held off by hold), delays each through a
// PIPE_LATENCY-deep shift register and turns the delayed strobe into the
// registered write enables and write index for the address controller.
module vector_update_sequencer #(
  parameter int no_of_units   = 8,
  parameter int PIPE_LATENCY  = 4,
  parameter int address_width = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     mode,
  input  logic [31:0]              total,
  input  logic                     hold,
  output logic                     read_again,
  output logic                     read_again_2,
  output logic                     result_mem_we_4,
  output logic                     result_mem_we_5,
  output logic                     result_mem_we_6,
  output logic [address_width-1:0] result_mem_counter_5,
  output logic                     busy,
  output logic                     done
);

  // Stages held in flops; the last stage feeds the registered write strobes.
  localparam int SR_W = (PIPE_LATENCY > 1) ? (PIPE_LATENCY - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [31:0]              n_q, n_d;
  logic [31:0]              issue_cnt_q, issue_cnt_d;
  logic [31:0]              write_cnt_q, write_cnt_d;
  logic [SR_W-1:0]          sr_q, sr_d;
  logic                     we4_q, we4_d;
  logic                     we5_q, we5_d;
  logic                     we6_q, we6_d;
  logic [address_width-1:0] cnt5_q, cnt5_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     last_wr_q, last_wr_d;

  logic                     rd_s;
  logic                     tap_s;
  logic [PIPE_LATENCY-1:0]  line_s;

  // Read strobe follows hold in the same cycle so a held cycle never reads.
  assign rd_s         = (state_q == S_ISSUE) && !hold;
  assign read_again   = rd_s && !mode_q;
  assign read_again_2 = rd_s && mode_q;

  assign result_mem_we_4      = we4_q;
  assign result_mem_we_5      = we5_q;
  assign result_mem_we_6      = we6_q;
  assign result_mem_counter_5 = cnt5_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

  // Delay line view: stage 0 is the live read strobe, the top stage is the tap.
  always_comb begin
    line_s    = '0;
    line_s[0] = rd_s;
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      line_s[i] = sr_q[i-1];
    end
    tap_s = line_s[PIPE_LATENCY-1];
    sr_d  = line_s[SR_W-1:0];
  end

  // Next-state, counter and write-strobe computation.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    write_cnt_d = write_cnt_q;
    cnt5_d      = cnt5_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // A tap hit is a write cycle; the index holds between writes.
    if (tap_s) begin
      we4_d       = !mode_q;
      we5_d       = !mode_q;
      we6_d       = mode_q;
      cnt5_d      = write_cnt_q[address_width-1:0];
      write_cnt_d = write_cnt_q + 32'd1;
      last_wr_d   = (write_cnt_q == (n_q - 32'd1));
    end else begin
      we4_d     = 1'b0;
      we5_d     = 1'b0;
      we6_d     = 1'b0;
      last_wr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          mode_d      = mode;
          n_d         = total / 32'(no_of_units);
          issue_cnt_d = 32'd0;
          write_cnt_d = 32'd0;
          if (n_d != 32'd0) begin
            state_d = S_ISSUE;
            busy_d  = 1'b1;
          end else begin
            // Empty pass: report completion immediately without going busy.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (rd_s) begin
          issue_cnt_d = issue_cnt_q + 32'd1;
          if (issue_cnt_q == (n_q - 32'd1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // last_wr_q is high in the cycle the final write strobe is on the port.
        if (last_wr_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      n_q         <= 32'd0;
      issue_cnt_q <= 32'd0;
      write_cnt_q <= 32'd0;
      sr_q        <= '0;
      we4_q       <= 1'b0;
      we5_q       <= 1'b0;
      we6_q       <= 1'b0;
      cnt5_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      write_cnt_q <= write_cnt_d;
      sr_q        <= sr_d;
      we4_q       <= we4_d;
      we5_q       <= we5_d;
      we6_q       <= we6_d;
      cnt5_q      <= cnt5_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_wr_q   <= last_wr_d;
    end
  end

endmodule
